bus_mux_reg: RTL and testbench
==============================

// Module: bus_mux_reg
// PURPOSE
//  Parametrised, registered CPU datapath bus. Selects one of N_SRC source words via
//  per-source drive enables and registers the result, so bus_out changes only on clk.
//  Resolves multiple simultaneous drivers by priority and reports them as conflicts.
//  Sits between the register file/special registers (HI, LO, Z, PC, MDR, InPort, C, MAR)
//  and every bus consumer.
// PARAMETERS
//  WIDTH      32  bits per bus word
//  N_SRC      25  number of sources (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, Csign, MAR)
//  PRIO_HIGH  1   1: highest-index asserted enable wins; 0: lowest-index enable wins
//  HOLD_IDLE  1   1: bus_out keeps its last value when no enable is set; 0: loads zero
//  CNT_W      8   width of the saturating conflict counter
// PORTS
//  clk              in   1              rising-edge clock
//  clr              in   1              asynchronous reset, active-high
//  src_data         in   N_SRC*WIDTH    source words; source i is src_data[i*WIDTH +: WIDTH]
//  src_out          in   N_SRC          drive enables, one per source (intended one-hot)
//  hold             in   1              freeze all registered outputs this cycle
//  err_clr          in   1              clear conflict_sticky and conflict_cnt
//  bus_out          out  WIDTH          registered bus value
//  bus_valid        out  1              1 when bus_out was loaded from a driver last edge
//  bus_src          out  $clog2(N_SRC)  index of the source loaded into bus_out
//  conflict         out  1              1-cycle flag: >1 enable seen at last load
//  conflict_sticky  out  1              set by any conflict, held until err_clr/clr
//  conflict_cnt     out  CNT_W          saturating count of conflict cycles
// BEHAVIOUR
//  - Reset (clr=1, async): all outputs 0. The reset is asynchronous; the state is 0
//    immediately, regardless of clk.
//  - Latency: 1 clk. Enables/data sampled at edge k, visible on bus_out after edge k.
//  - Load (hold=0, any src_out bit set):
//    - winner = priority-encoded index (PRIO_HIGH selects the direction).
//    - bus_out <= src_data[winner]; bus_src <= winner; bus_valid <= 1.
//  - Idle (hold=0, src_out=0):
//    - bus_valid <= 0; conflict <= 0.
//    - HOLD_IDLE=1: bus_out and bus_src unchanged.
//    - HOLD_IDLE=0: bus_out <= 0; bus_src unchanged.
//  - hold=1: every register, including the counter and sticky flag, keeps its value.
//    hold overrides both load and err_clr.
//  - Conflict (hold=0, popcount(src_out)>=2): the load proceeds with the winner, and
//    conflict <= 1, conflict_sticky <= 1, conflict_cnt <= cnt+1.
//    The counter saturates at 2**CNT_W-1 and never wraps.
//  - No conflict (hold=0): conflict <= 0.
//  - err_clr=1 with hold=0:
//    - conflict_sticky <= 0, conflict_cnt <= 0, even in a conflict cycle
//      (clear beats set).
//    - conflict still reflects the current cycle.
//  - Out-of-range: src_out bits at index >= N_SRC do not exist; no X propagation is
//    allowed from an unused data slice.
//  - clr asserted mid-operation: the next edge after release behaves as a first load;
//    there is no memory of pre-reset enables.
// STRUCTURE
//  - Shared package cpu_bus_pkg:
//    - source-index localparams SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO,
//      SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN, SRC_MAR;
//    - BUS_W=32 and N_BUS_SRC=25.
//  - One sub-module, bus_prio_enc, purely combinational:
//    - input: the N_SRC enables; parameter PRIO_HIGH;
//    - outputs: winner index, any, multi.
//  - Top level: the data mux indexed by winner, plus output, flag and counter registers.
// TESTING
//  1. clr=1 mid-run with bus_out=0xDEADBEEF -> all outputs 0 immediately, before any
//     clk edge.
//  2. src_out=1<<20 (PC), PC data=0x00000040 -> after 1 edge: bus_out=0x40, bus_src=20,
//     bus_valid=1, conflict=0.
//  3. src_out=(1<<3)|(1<<21), R3=0x11, MDR=0x22, PRIO_HIGH=1 -> bus_out=0x22, bus_src=21,
//     conflict=1, sticky=1, cnt=1. With PRIO_HIGH=0 -> bus_out=0x11, bus_src=3.
//  4. Load 0x55 then src_out=0 -> HOLD_IDLE=1: bus_out stays 0x55, bus_valid=0;
//     HOLD_IDLE=0: bus_out=0.
//  5. CNT_W=2, 5 consecutive conflict cycles -> cnt 1,2,3,3,3.
//     err_clr=1 in a conflict cycle -> cnt=0, sticky=0, conflict=1.
//  6. hold=1 with src_out=1<<0, err_clr=1 -> bus_out, bus_src, cnt and sticky all
//     unchanged for every held cycle; normal load resumes on the first edge with hold=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: bus geometry and the fixed index of every bus source.
package cpu_bus_pkg;

    localparam int BUS_W     = 32;
    localparam int N_BUS_SRC = 25;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;
    localparam int SRC_MAR    = 24;

endpackage

// File: rtl/bus_prio_enc.sv
// Priority encoder over the bus drive enables; also flags any/multiple drivers.
module bus_prio_enc #(
    parameter int N_SRC     = 25,
    parameter int PRIO_HIGH = 1,
    parameter int SRC_W     = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] en,
    output logic [SRC_W-1:0] winner,
    output logic             any,
    output logic             multi
);

    // Ascending scan: with PRIO_HIGH the last set bit overwrites, otherwise the first one sticks.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        multi  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (en[i]) begin
                if (any) multi = 1'b1;
                if (PRIO_HIGH != 0 || !any) winner = SRC_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered CPU datapath bus: priority-selects one source word per clock and
// tracks multiple-driver conflicts with a one-cycle flag, a sticky flag and a counter.
module bus_mux_reg
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH     = BUS_W,
    parameter int N_SRC     = N_BUS_SRC,
    parameter int PRIO_HIGH = 1,
    parameter int HOLD_IDLE = 1,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         src_out,
    input  logic                     hold,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [$clog2(N_SRC)-1:0] bus_src,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SRC_W-1:0] winner;
    logic             any;
    logic             multi;
    logic [WIDTH-1:0] sel_word;

    bus_prio_enc #(
        .N_SRC     (N_SRC),
        .PRIO_HIGH (PRIO_HIGH),
        .SRC_W     (SRC_W)
    ) u_enc (
        .en     (src_out),
        .winner (winner),
        .any    (any),
        .multi  (multi)
    );

    // winner is always a real source index, so no unused slice can reach the bus.
    assign sel_word = src_data[winner*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_out         <= '0;
            bus_valid       <= 1'b0;
            bus_src         <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else if (!hold) begin
            conflict <= multi;
            if (any) begin
                bus_out   <= sel_word;
                bus_src   <= winner;
                bus_valid <= 1'b1;
            end else begin
                bus_valid <= 1'b0;
                if (HOLD_IDLE == 0) bus_out <= '0;
            end
            // Clearing wins over a conflict seen in the same cycle.
            if (err_clr) begin
                conflict_sticky <= 1'b0;
                conflict_cnt    <= '0;
            end else if (multi) begin
                conflict_sticky <= 1'b1;
                if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: two configurations share one stimulus stream and are
// checked against a rule-level reference model.
module tb_bus_mux_reg;

    localparam int W = 32;
    localparam int N = 25;

    logic           clk = 1'b0;
    logic           clr;
    logic [W-1:0]   words [N];
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_out;
    logic           hold;
    logic           err_clr;

    logic [W-1:0] a_bus, b_bus;
    logic         a_valid, b_valid;
    logic [4:0]   a_src, b_src;
    logic         a_conf, b_conf;
    logic         a_sticky, b_sticky;
    logic [1:0]   a_cnt;
    logic [7:0]   b_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state, index 0 = u_a, 1 = u_b
    logic [W-1:0] m_bus [2];
    logic         m_valid [2];
    int           m_src [2];
    logic         m_conf [2];
    logic         m_sticky [2];
    int           m_cnt [2];
    int           prio_high [2] = '{1, 0};
    int           hold_idle [2] = '{1, 0};
    int           cnt_max [2]   = '{3, 255};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign src_data[g*W +: W] = words[g];
    end

    bus_mux_reg #(.WIDTH(W), .N_SRC(N), .PRIO_HIGH(1), .HOLD_IDLE(1), .CNT_W(2)) u_a (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .hold(hold),
        .err_clr(err_clr), .bus_out(a_bus), .bus_valid(a_valid), .bus_src(a_src),
        .conflict(a_conf), .conflict_sticky(a_sticky), .conflict_cnt(a_cnt)
    );

    bus_mux_reg #(.WIDTH(W), .N_SRC(N), .PRIO_HIGH(0), .HOLD_IDLE(0), .CNT_W(8)) u_b (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .hold(hold),
        .err_clr(err_clr), .bus_out(b_bus), .bus_valid(b_valid), .bus_src(b_src),
        .conflict(b_conf), .conflict_sticky(b_sticky), .conflict_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_bus[k] = '0; m_valid[k] = 0; m_src[k] = 0;
            m_conf[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // Apply the bus rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int drivers[$];
        int w;
        drivers = {};
        for (int i = 0; i < N; i++) if (src_out[i]) drivers.push_back(i);
        if (!hold) begin
            for (int k = 0; k < 2; k++) begin
                if (drivers.size() > 0) begin
                    w = (prio_high[k] != 0) ? drivers[drivers.size()-1] : drivers[0];
                    m_bus[k] = words[w]; m_src[k] = w; m_valid[k] = 1;
                end else begin
                    m_valid[k] = 0;
                    if (hold_idle[k] == 0) m_bus[k] = '0;
                end
                m_conf[k] = (drivers.size() >= 2);
                if (err_clr) begin
                    m_sticky[k] = 0; m_cnt[k] = 0;
                end else if (drivers.size() >= 2) begin
                    m_sticky[k] = 1;
                    if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a.bus_out", a_bus, m_bus[0]);
        chk("a.bus_valid", W'(a_valid), W'(m_valid[0]));
        chk("a.bus_src", W'(a_src), W'(m_src[0]));
        chk("a.conflict", W'(a_conf), W'(m_conf[0]));
        chk("a.sticky", W'(a_sticky), W'(m_sticky[0]));
        chk("a.cnt", W'(a_cnt), W'(m_cnt[0]));
        chk("b.bus_out", b_bus, m_bus[1]);
        chk("b.bus_valid", W'(b_valid), W'(m_valid[1]));
        chk("b.bus_src", W'(b_src), W'(m_src[1]));
        chk("b.conflict", W'(b_conf), W'(m_conf[1]));
        chk("b.sticky", W'(b_sticky), W'(m_sticky[1]));
        chk("b.cnt", W'(b_cnt), W'(m_cnt[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Pulse clr between edges and confirm the outputs clear without a clock.
    task automatic async_clear();
        #2 clr = 1'b1;
        model_reset();
        #1;
        check_all();
        #1 clr = 1'b0;
    endtask

    task automatic set_inputs(input logic [N-1:0] en, input logic hl, input logic ec);
        src_out = en; hold = hl; err_clr = ec;
    endtask

    initial begin
        clr = 1'b1;
        set_inputs('0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) words[i] = $urandom;
        model_reset();
        #1 check_all();
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        // async reset with a live value on the bus
        words[0] = 32'hDEADBEEF;
        set_inputs(25'd1, 1'b0, 1'b0);
        step();
        chk("pre_clr.bus_out", a_bus, 32'hDEADBEEF);
        async_clear();

        // single driver: PC
        words[20] = 32'h0000_0040;
        set_inputs(25'(1) << 20, 1'b0, 1'b0);
        step();
        chk("pc.bus_out", a_bus, 32'h40);
        chk("pc.bus_src", W'(a_src), 32'd20);

        // R3 and MDR together
        words[3] = 32'h11; words[21] = 32'h22;
        set_inputs((25'(1) << 3) | (25'(1) << 21), 1'b0, 1'b0);
        step();
        chk("conf_hi.bus_out", a_bus, 32'h22);
        chk("conf_hi.cnt", W'(a_cnt), 32'd1);
        chk("conf_lo.bus_out", b_bus, 32'h11);
        chk("conf_lo.bus_src", W'(b_src), 32'd3);

        // idle after loading 0x55
        words[5] = 32'h55;
        set_inputs(25'(1) << 5, 1'b0, 1'b0);
        step();
        set_inputs('0, 1'b0, 1'b0);
        step();
        chk("idle_hold.bus_out", a_bus, 32'h55);
        chk("idle_zero.bus_out", b_bus, 32'h0);

        // err_clr during a conflict, then saturation of the 2-bit counter
        set_inputs((25'(1) << 3) | (25'(1) << 21), 1'b0, 1'b1);
        step();
        chk("clr_in_conf.conflict", W'(a_conf), 32'd1);
        chk("clr_in_conf.cnt", W'(a_cnt), 32'd0);
        set_inputs((25'(1) << 3) | (25'(1) << 21), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat.cnt", W'(a_cnt), (i < 3) ? W'(i + 1) : 32'd3);
        end

        // hold freezes everything, including err_clr
        set_inputs(25'd1, 1'b1, 1'b1);
        words[0] = 32'hCAFE_0001;
        repeat (3) begin
            step();
            chk("hold.cnt", W'(a_cnt), 32'd3);
            chk("hold.bus_out", a_bus, 32'h22);
        end
        set_inputs(25'd1, 1'b0, 1'b0);
        step();
        chk("resume.bus_out", a_bus, 32'hCAFE_0001);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int mode;
            for (int i = 0; i < N; i++) words[i] = $urandom;
            mode = $urandom_range(0, 9);
            if (mode < 2) src_out = '0;
            else if (mode < 7) src_out = 25'(1) << $urandom_range(0, N - 1);
            else src_out = 25'($urandom);
            hold = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 5) == 0);
            step();
            if ($urandom_range(0, 39) == 0) async_clear();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
